// File: rtl/lfsr_card_rng.sv
// lfsr_card_rng: parametrised Fibonacci LFSR with a req/ack draw port.
// A draw returns an unbiased card in 0..RANGE-1 by rejection sampling of
// the low SAMPLE_BITS of the LFSR state, bounded to MAX_TRIES samples; the
// last rejected sample is folded into range by subtracting RANGE.
// Optional feature macro: LFSR_ZERO_GUARD_EN (reseeds on an all-zero state
// or an all-zero seed load instead of locking up).
module lfsr_card_rng #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] TAPS        = 32'h0000_002D,
  parameter logic [31:0] RESET_SEED  = 32'h0000_1ACE,
  parameter int          RANGE       = 13,
  parameter int          SAMPLE_BITS = 4,
  parameter int          MAX_TRIES   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   req,
  input  logic                   ack,
  output logic [WIDTH-1:0]       rnd,
  output logic [SAMPLE_BITS-1:0] card,
  output logic                   valid,
  output logic                   busy
);

  // One spare bit so the counter can never wrap, even at MAX_TRIES = 2^n.
  localparam int TRY_W = $clog2(MAX_TRIES) + 1;

  localparam logic [WIDTH-1:0]       TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0]       SEED_INIT = RESET_SEED[WIDTH-1:0];
  // RANGE may equal 2^SAMPLE_BITS, so compare against it one bit wider.
  localparam logic [SAMPLE_BITS:0]   RANGE_EXT = (SAMPLE_BITS + 1)'(RANGE);
  localparam logic [SAMPLE_BITS-1:0] RANGE_LOW = RANGE_EXT[SAMPLE_BITS-1:0];
  localparam logic [TRY_W-1:0]       LAST_TRY  = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       rnd_reg, rnd_next;
  logic [SAMPLE_BITS-1:0] card_reg, card_next;
  logic                   valid_reg, valid_next;
  logic [TRY_W-1:0]       try_reg, try_next;

  logic                   fb;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   in_range;

  assign fb       = ^(rnd_reg & TAP_MASK);
  assign sample   = rnd_reg[SAMPLE_BITS-1:0];
  assign in_range = ({1'b0, sample} < RANGE_EXT);

  // LFSR next state: load wins over shifting; optional zero-state recovery.
  always_comb begin
    rnd_next = {fb, rnd_reg[WIDTH-1:1]};
`ifdef LFSR_ZERO_GUARD_EN
    if (load) begin
      rnd_next = (seed == '0) ? SEED_INIT : seed;
    end else if (rnd_reg == '0) begin
      rnd_next = SEED_INIT;
    end
`else
    if (load) begin
      rnd_next = seed;
    end
`endif
  end

  // Draw FSM next state and registered-output next values.
  always_comb begin
    state_next = state_reg;
    card_next  = card_reg;
    valid_next = valid_reg;
    try_next   = try_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = DRAW;
          try_next   = '0;
        end
      end
      DRAW: begin
        if (in_range) begin
          card_next  = sample;
          valid_next = 1'b1;
          state_next = HOLD;
        end else if (try_reg < LAST_TRY) begin
          try_next = try_reg + TRY_W'(1);
        end else begin
          // Out-of-range sample lies in RANGE..2*RANGE-1, so this is < RANGE.
          card_next  = sample - RANGE_LOW;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, LFSR and output registers; reset discards any in-flight draw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rnd_reg   <= SEED_INIT;
      card_reg  <= '0;
      valid_reg <= 1'b0;
      try_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      card_reg  <= card_next;
      valid_reg <= valid_next;
      try_reg   <= try_next;
    end
  end

  assign rnd   = rnd_reg;
  assign card  = card_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_lfsr_card_rng.sv
// Directed testbench for lfsr_card_rng. Two instances share clock, reset,
// load and seed: dut0 uses default parameters, dut1 uses MAX_TRIES=1 to
// exercise the fallback path. Expected values are hand-computed from the
// default taps (bits 0,2,3,5) and range 13.
module tb_lfsr_card_rng;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] seed;
  logic        req;
  logic        ack;
  logic        req1;
  logic        ack1;

  logic [15:0] rnd;
  logic [3:0]  card;
  logic        valid;
  logic        busy;
  logic [15:0] rnd1;
  logic [3:0]  card1;
  logic        valid1;
  logic        busy1;

  int vectors;
  int miscompares;

  lfsr_card_rng dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (seed),
    .req   (req),
    .ack   (ack),
    .rnd   (rnd),
    .card  (card),
    .valid (valid),
    .busy  (busy)
  );

  lfsr_card_rng #(.MAX_TRIES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (seed),
    .req   (req1),
    .ack   (ack1),
    .rnd   (rnd1),
    .card  (card1),
    .valid (valid1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; seed = 16'h0000;
    req = 1'b0; ack = 1'b0; req1 = 1'b0; ack1 = 1'b0;
    step(); step();
    vectors++;
    if (rnd !== 16'h1ACE) begin miscompares++; $display("FAIL reset_rnd: got %h expected %h", rnd, 16'h1ACE); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (card !== 4'd0) begin miscompares++; $display("FAIL reset_card: got %0d expected 0", card); end
    vectors++;
    if (rnd1 !== 16'h1ACE) begin miscompares++; $display("FAIL reset_rnd1: got %h expected %h", rnd1, 16'h1ACE); end
    #2 rst_n = 1'b1;
    step();
    vectors++;
    if (rnd !== 16'h0D67) begin miscompares++; $display("FAIL first_shift: got %h expected %h", rnd, 16'h0D67); end
    $display("test_reset done");
  endtask

  task automatic test_draw_accept();
    load = 1'b1; seed = 16'h0007; req = 1'b1;
    step();
    load = 1'b0; req = 1'b0;
    vectors++;
    if (rnd !== 16'h0007) begin miscompares++; $display("FAIL accept_load: got %h expected %h", rnd, 16'h0007); end
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL accept_draw: got busy=%b valid=%b expected busy=1 valid=0", busy, valid); end
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd7) begin miscompares++; $display("FAIL accept_card: got valid=%b card=%0d expected valid=1 card=7", valid, card); end
    step(); step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd7) begin miscompares++; $display("FAIL accept_hold: got valid=%b card=%0d expected valid=1 card=7", valid, card); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL accept_ack: got valid=%b busy=%b expected 0 0", valid, busy); end
    $display("test_draw_accept done");
  endtask

  task automatic test_reject();
    load = 1'b1; seed = 16'h000E; req = 1'b1;
    step();
    load = 1'b0; req = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL reject_first: got valid=%b busy=%b expected valid=0 busy=1", valid, busy); end
    vectors++;
    if (rnd !== 16'h0007) begin miscompares++; $display("FAIL reject_rnd: got %h expected %h", rnd, 16'h0007); end
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd7) begin miscompares++; $display("FAIL reject_card: got valid=%b card=%0d expected valid=1 card=7", valid, card); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reject_ack: got valid=%b busy=%b expected 0 0", valid, busy); end
    $display("test_reject done");
  endtask

  task automatic test_fallback();
    load = 1'b1; seed = 16'h000E; req1 = 1'b1;
    step();
    load = 1'b0; req1 = 1'b0;
    vectors++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0) begin miscompares++; $display("FAIL fallback_draw: got busy=%b valid=%b expected 1 0", busy1, valid1); end
    step();
    vectors++;
    if (valid1 !== 1'b1 || card1 !== 4'd1) begin miscompares++; $display("FAIL fallback_card: got valid=%b card=%0d expected valid=1 card=1", valid1, card1); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL fallback_other_idle: got busy=%b expected 0", busy); end
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    vectors++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL fallback_ack: got valid=%b busy=%b expected 0 0", valid1, busy1); end
    $display("test_fallback done");
  endtask

  task automatic test_load_during_draw();
    load = 1'b1; seed = 16'h000E; req = 1'b1;
    step();
    seed = 16'h0003; req = 1'b0;
    step();
    load = 1'b0;
    vectors++;
    if (rnd !== 16'h0003 || valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL midload_state: got rnd=%h valid=%b busy=%b expected 0003 0 1", rnd, valid, busy); end
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd3) begin miscompares++; $display("FAIL midload_card: got valid=%b card=%0d expected valid=1 card=3", valid, card); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    $display("test_load_during_draw done");
  endtask

  task automatic test_back_to_back();
    load = 1'b1; seed = 16'h0007; req = 1'b1;
    step();
    load = 1'b0; req = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd7) begin miscompares++; $display("FAIL b2b_first: got valid=%b card=%0d expected valid=1 card=7", valid, card); end
    ack = 1'b1; req = 1'b1;
    step();
    ack = 1'b0; load = 1'b1; seed = 16'h0005;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_release: got valid=%b busy=%b expected 0 0", valid, busy); end
    step();
    load = 1'b0; req = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rnd !== 16'h0005) begin miscompares++; $display("FAIL b2b_rearm: got busy=%b rnd=%h expected 1 0005", busy, rnd); end
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd5) begin miscompares++; $display("FAIL b2b_second: got valid=%b card=%0d expected valid=1 card=5", valid, card); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_zero_seed();
    load = 1'b1; seed = 16'h0000;
    step();
    load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    vectors++;
    if (rnd !== 16'h1ACE) begin miscompares++; $display("FAIL zero_guard: got %h expected %h", rnd, 16'h1ACE); end
`else
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (rnd !== 16'h0000) begin miscompares++; $display("FAIL zero_lock[%0d]: got %h expected 0000", i, rnd); end
      step();
    end
`endif
    load = 1'b1; seed = 16'h1ACE;
    step();
    load = 1'b0;
    $display("test_zero_seed done");
  endtask

  task automatic test_async_reset();
    load = 1'b1; seed = 16'h000E; req = 1'b1;
    step();
    load = 1'b0; req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got busy=%b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || rnd !== 16'h1ACE) begin miscompares++; $display("FAIL areset_now: got valid=%b busy=%b rnd=%h expected 0 0 1ace", valid, busy, rnd); end
    #1 rst_n = 1'b1;
    step();
    vectors++;
    if (rnd !== 16'h0D67 || busy !== 1'b0) begin miscompares++; $display("FAIL areset_release: got rnd=%h busy=%b expected 0d67 0", rnd, busy); end
    load = 1'b1; seed = 16'h0007; req = 1'b1;
    step();
    load = 1'b0; req = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || card !== 4'd7) begin miscompares++; $display("FAIL areset_redraw: got valid=%b card=%0d expected valid=1 card=7", valid, card); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    $display("test_async_reset done");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_draw_accept();
    test_reject();
    test_fallback();
    test_load_during_draw();
    test_back_to_back();
    test_zero_seed();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
